// File: rtl/ramp_framer.sv
// rtl/ramp_framer.sv - frames decimated ADC samples into a header + counter + hi/lo byte stream per chirp
module ramp_framer #(
  parameter int DW         = 14,
  parameter int USBDW      = 8,
  parameter int FRAME_LEN  = 1024,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             ramp_start_i,
  input  logic [DW-1:0]    data_i,
  input  logic             valid_i,
  output logic [USBDW-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             overflow_o,
  input  logic             ovf_clr_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   ROOM2_C = (AW+1)'(FIFO_DEPTH - 2);
  localparam logic [CW-1:0] LAST_C  = CW'(FRAME_LEN - 1);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, HCNT, PAY, LO} state_t;

  state_t           state_q;
  logic [CW-1:0]    scnt_q;
  logic [7:0]       frame_cnt_q;
  logic [13:0]      hold_q;
  logic             hold_v_q;
  logic [7:0]       lo_q;
  logic             ovf_q;

  logic [USBDW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q, count_d;

  logic [13:0]      s14;
  logic             full, room2, accept, consume, capture_req, capture, drop;
  logic             wr_en, push, pop;
  logic [USBDW-1:0] wr_data;

  assign s14         = 14'($signed(data_i));
  assign full        = (count_q == DEPTH_C);
  assign room2       = (count_q <= ROOM2_C);
  assign accept      = (state_q == IDLE) && ramp_start_i && en_i;
  assign consume     = (state_q == PAY) && hold_v_q && room2;
  assign capture_req = valid_i && ((state_q != IDLE) || accept);
  // A held sample being consumed this cycle frees the slot for the new one.
  assign capture     = capture_req && (!hold_v_q || consume);
  assign drop        = capture_req && hold_v_q && !consume;

  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (state_q)
      HDR0, HDR1: begin wr_en = 1'b1;    wr_data = 8'hFF; end
      HCNT:       begin wr_en = 1'b1;    wr_data = frame_cnt_q; end
      PAY:        begin wr_en = consume; wr_data = {2'b00, hold_q[13:8]}; end
      LO:         begin wr_en = 1'b1;    wr_data = lo_q; end
      default:    ;
    endcase
  end

  assign push = wr_en && !full;
  assign pop  = valid_o && ready_i;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  assign valid_o    = (count_q != '0);
  assign data_o     = valid_o ? mem_q[rptr_q] : '0;
  assign busy_o     = (state_q != IDLE);
  assign overflow_o = ovf_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      scnt_q      <= '0;
      frame_cnt_q <= '0;
      hold_q      <= '0;
      hold_v_q    <= 1'b0;
      lo_q        <= '0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= HDR0;
          scnt_q  <= '0;
        end
        HDR0: if (!full) state_q <= HDR1;
        HDR1: if (!full) state_q <= HCNT;
        HCNT: if (!full) state_q <= PAY;
        PAY: if (consume) begin
          lo_q    <= hold_q[7:0];
          state_q <= LO;
        end
        LO: begin
          if (scnt_q == LAST_C) begin
            state_q     <= IDLE;
            frame_cnt_q <= frame_cnt_q + 8'd1;
          end else begin
            scnt_q  <= scnt_q + CW'(1);
            state_q <= PAY;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (capture) begin
        hold_q   <= s14;
        hold_v_q <= 1'b1;
      end else if (consume) begin
        hold_v_q <= 1'b0;
      end

      if (drop)           ovf_q <= 1'b1;
      else if (ovf_clr_i) ovf_q <= 1'b0;
    end
  end

endmodule
